// File: rtl/i2s_adc_receiver.sv
// ---------------------------------------------------------------------------
// i2s_adc_receiver
//
// Purpose:
//   Deserializes the WM8731 I2S ADC stream into parallel signed left/right
//   samples in the CLOCK_50 domain. The codec is bus master, so the bit
//   clock, frame clock and serial data all arrive asynchronously and are
//   oversampled by CLOCK_50. It is the capture-side counterpart of the DAC
//   serializer and feeds the adc_left/adc_right voice pass-through path.
//
// Parameters:
//   WIDTH        sample width per channel (MSB first, two's complement),
//                at most 31 so the 5-bit bit counter can hold it
//
// Ports:
//   CLOCK_50     in   1      system clock, all outputs registered on it
//   reset        in   1      asynchronous active-low reset
//   AUD_BCLK     in   1      codec bit clock (asynchronous)
//   AUD_ADCLRCK  in   1      codec frame clock, low = left, high = right
//   AUD_ADCDAT   in   1      codec serial ADC data
//   adc_left     out  WIDTH  last complete left sample
//   adc_right    out  WIDTH  last complete right sample
//   sample_valid out  1      one-cycle pulse, both samples just updated
//   frame_error  out  1      one-cycle pulse, channel word was truncated
// ---------------------------------------------------------------------------
module i2s_adc_receiver #(
  parameter int WIDTH = 24
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             AUD_BCLK,
  input  logic             AUD_ADCLRCK,
  input  logic             AUD_ADCDAT,
  output logic [WIDTH-1:0] adc_left,
  output logic [WIDTH-1:0] adc_right,
  output logic             sample_valid,
  output logic             frame_error
);

  // A bit count of WIDTH means "no word in progress": either the word is
  // complete and further bits are slot padding, or we are still waiting for
  // the first frame-clock edge after reset.
  localparam logic [4:0] FULL = 5'(WIDTH);
  localparam logic [4:0] LAST = 5'(WIDTH - 1);

  typedef enum logic {
    CHAN_LEFT  = 1'b0,
    CHAN_RIGHT = 1'b1
  } chan_t;

  logic [2:0] bclk_sync;
  logic [1:0] lrck_sync;
  logic [1:0] dat_sync;

  logic       bclk_rise;
  logic       lrck_now;
  logic       dat_now;

  logic             lrck_prev_q,  lrck_prev_n;
  logic             aligned_q,    aligned_n;
  logic             first_slot_q, first_slot_n;
  logic [4:0]       bit_cnt_q,    bit_cnt_n;
  chan_t            chan_q,       chan_n;
  logic [WIDTH-1:0] shift_q,      shift_n;
  logic [WIDTH-1:0] left_hold_q,  left_hold_n;
  logic             left_ok_q,    left_ok_n;
  logic [WIDTH-1:0] adc_left_n;
  logic [WIDTH-1:0] adc_right_n;
  logic             sample_valid_n;
  logic             frame_error_n;

  // All three codec pins go through synchronizers of the same depth, so the
  // frame clock and data seen when the bit-clock rise is detected were
  // captured on the same CLOCK_50 edge as the rising bit clock itself. The
  // extra bit-clock stage only serves the edge detector.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      bclk_sync <= '0;
      lrck_sync <= '0;
      dat_sync  <= '0;
    end else begin
      bclk_sync <= {bclk_sync[1:0], AUD_BCLK};
      lrck_sync <= {lrck_sync[0], AUD_ADCLRCK};
      dat_sync  <= {dat_sync[0], AUD_ADCDAT};
    end
  end

  assign bclk_rise = bclk_sync[1] & ~bclk_sync[2];
  assign lrck_now  = lrck_sync[1];
  assign dat_now   = dat_sync[1];

  // Protocol state register. The first-slot flag starts set and an extra
  // "aligned" bit remembers whether any frame-clock edge has been seen yet,
  // so the slot opened by the first edge (which may begin mid-channel) is
  // never reported as truncated.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      lrck_prev_q  <= 1'b0;
      aligned_q    <= 1'b0;
      first_slot_q <= 1'b1;
      bit_cnt_q    <= FULL;
      chan_q       <= CHAN_LEFT;
      shift_q      <= '0;
      left_hold_q  <= '0;
      left_ok_q    <= 1'b0;
      adc_left     <= '0;
      adc_right    <= '0;
      sample_valid <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      lrck_prev_q  <= lrck_prev_n;
      aligned_q    <= aligned_n;
      first_slot_q <= first_slot_n;
      bit_cnt_q    <= bit_cnt_n;
      chan_q       <= chan_n;
      shift_q      <= shift_n;
      left_hold_q  <= left_hold_n;
      left_ok_q    <= left_ok_n;
      adc_left     <= adc_left_n;
      adc_right    <= adc_right_n;
      sample_valid <= sample_valid_n;
      frame_error  <= frame_error_n;
    end
  end

  // Next-state logic. Nothing moves except on a detected bit-clock rise.
  // A frame-clock change marks the I2S one-bit delay slot, whose data bit
  // is dropped. Otherwise bits shift in MSB first until WIDTH have arrived;
  // later bits are padding. A left word is parked in left_hold and only
  // published together with the following right word, so the two outputs
  // always change as a matched pair. Errors can only arise on a frame-clock
  // change and completions only on a shift, so the two pulses never overlap.
  always_comb begin
    lrck_prev_n    = lrck_prev_q;
    aligned_n      = aligned_q;
    first_slot_n   = first_slot_q;
    bit_cnt_n      = bit_cnt_q;
    chan_n         = chan_q;
    shift_n        = shift_q;
    left_hold_n    = left_hold_q;
    left_ok_n      = left_ok_q;
    adc_left_n     = adc_left;
    adc_right_n    = adc_right;
    sample_valid_n = 1'b0;
    frame_error_n  = 1'b0;

    if (bclk_rise) begin
      lrck_prev_n = lrck_now;
      if (lrck_now != lrck_prev_q) begin
        if ((bit_cnt_q != FULL) && !first_slot_q) begin
          frame_error_n = 1'b1;
        end
        first_slot_n = ~aligned_q;
        aligned_n    = 1'b1;
        bit_cnt_n    = 5'd0;
        chan_n       = lrck_now ? CHAN_RIGHT : CHAN_LEFT;
        shift_n      = '0;
        if (!lrck_now) begin
          left_ok_n = 1'b0;
        end
      end else if (bit_cnt_q < FULL) begin
        shift_n   = {shift_q[WIDTH-2:0], dat_now};
        bit_cnt_n = bit_cnt_q + 5'd1;
        if (bit_cnt_q == LAST) begin
          if (chan_q == CHAN_LEFT) begin
            left_hold_n = shift_n;
            left_ok_n   = 1'b1;
          end else if (left_ok_q) begin
            adc_left_n     = left_hold_q;
            adc_right_n    = shift_n;
            sample_valid_n = 1'b1;
            left_ok_n      = 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_adc_receiver.sv
// ---------------------------------------------------------------------------
// tb_i2s_adc_receiver
//
// Purpose:
//   Drives I2S frames into i2s_adc_receiver at slot granularity and compares
//   every CLOCK_50 cycle against a slot-level model of what the receiver
//   must report: which pairs are published, which slots are flagged as
//   truncated, and what the parallel outputs must hold in between.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_i2s_adc_receiver;

  localparam int WIDTH = 24;

  logic             CLOCK_50 = 1'b0;
  logic             reset;
  logic             AUD_BCLK;
  logic             AUD_ADCLRCK;
  logic             AUD_ADCDAT;
  logic [WIDTH-1:0] adc_left;
  logic [WIDTH-1:0] adc_right;
  logic             sample_valid;
  logic             frame_error;

  int total = 0;
  int bad   = 0;
  int sv_count  = 0;
  int err_count = 0;
  int half_ns   = 163;

  // Expected pulse: either a truncation error or a published pair.
  typedef struct packed {
    logic             is_err;
    logic [WIDTH-1:0] l;
    logic [WIDTH-1:0] r;
  } event_t;

  event_t           exp_q[$];
  event_t           cmp_ev;
  logic [WIDTH-1:0] exp_left  = '0;
  logic [WIDTH-1:0] exp_right = '0;

  // Slot-level model state.
  bit               m_aligned;
  bit               m_first;
  bit               m_left_ok;
  logic             m_prev_lr;
  int               m_prev_nbits;
  logic [WIDTH-1:0] m_hold;

  i2s_adc_receiver #(.WIDTH(WIDTH)) dut (
    .CLOCK_50     (CLOCK_50),
    .reset        (reset),
    .AUD_BCLK     (AUD_BCLK),
    .AUD_ADCLRCK  (AUD_ADCLRCK),
    .AUD_ADCDAT   (AUD_ADCDAT),
    .adc_left     (adc_left),
    .adc_right    (adc_right),
    .sample_valid (sample_valid),
    .frame_error  (frame_error)
  );

  // 50 MHz system clock.
  always #10 CLOCK_50 = ~CLOCK_50;

  function automatic void model_reset();
    exp_q.delete();
    m_aligned    = 1'b0;
    m_first      = 1'b1;
    m_left_ok    = 1'b0;
    m_prev_lr    = 1'b0;
    m_prev_nbits = WIDTH;
    m_hold       = '0;
  endfunction

  // One slot = a frame-clock level lr, the delay bit, then nbits data bits.
  // A slot shorter than WIDTH is a truncation, reported when the next slot
  // begins unless it was the slot opened by the first edge after reset.
  function automatic void model_slot(input logic lr, input logic [WIDTH-1:0] word,
                                     input int nbits);
    event_t ev;
    if (!m_aligned && (lr == m_prev_lr)) return;
    if (m_aligned && !m_first && (m_prev_nbits < WIDTH)) begin
      ev = '{is_err: 1'b1, l: '0, r: '0};
      exp_q.push_back(ev);
    end
    m_first      = !m_aligned;
    m_aligned    = 1'b1;
    m_prev_lr    = lr;
    m_prev_nbits = nbits;
    if (lr == 1'b0) m_left_ok = 1'b0;
    if (nbits >= WIDTH) begin
      if (lr == 1'b0) begin
        m_hold    = word;
        m_left_ok = 1'b1;
      end else if (m_left_ok) begin
        ev = '{is_err: 1'b0, l: m_hold, r: word};
        exp_q.push_back(ev);
        m_left_ok = 1'b0;
      end
    end
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // One bit clock period: pins change while the bit clock is low.
  task automatic apply_stimulus(input logic lr, input logic d);
    AUD_BCLK    = 1'b0;
    AUD_ADCLRCK = lr;
    AUD_ADCDAT  = d;
    #(half_ns);
    AUD_BCLK = 1'b1;
    #(half_ns);
  endtask

  task automatic send_slot(input logic lr, input logic [WIDTH-1:0] word, input int nbits);
    logic d;
    model_slot(lr, word, nbits);
    apply_stimulus(lr, 1'($urandom_range(0, 1)));
    for (int i = 0; i < nbits; i++) begin
      d = (i < WIDTH) ? word[WIDTH-1-i] : 1'($urandom_range(0, 1));
      apply_stimulus(lr, d);
    end
  endtask

  task automatic send_frame(input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] r,
                            input int nbits);
    send_slot(1'b0, l, nbits);
    send_slot(1'b1, r, nbits);
  endtask

  // Leave pin edges 3 ns after a rising CLOCK_50 edge.
  task automatic settle(input int n);
    repeat (n) @(posedge CLOCK_50);
    #3;
  endtask

  // Every cycle: pulses are matched in order against the model's queue and
  // the parallel outputs must equal the last published pair.
  always @(negedge CLOCK_50) begin
    if (!reset) begin
      exp_left  = '0;
      exp_right = '0;
    end
    if (sample_valid || frame_error) begin
      if (sample_valid) sv_count++;
      if (frame_error)  err_count++;
      total++;
      if (sample_valid && frame_error) begin
        bad++;
        $display("[TB] FAIL pulse overlap: sample_valid=1 frame_error=1 required not both");
      end
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("[TB] FAIL unexpected pulse: sample_valid=%b frame_error=%b required none",
                 sample_valid, frame_error);
      end else begin
        cmp_ev = exp_q.pop_front();
        if (cmp_ev.is_err !== frame_error) begin
          bad++;
          $display("[TB] FAIL pulse kind: frame_error=%b required %b", frame_error, cmp_ev.is_err);
        end
        if (!cmp_ev.is_err) begin
          exp_left  = cmp_ev.l;
          exp_right = cmp_ev.r;
        end
      end
    end
    total++;
    if ((adc_left !== exp_left) || (adc_right !== exp_right)) begin
      bad++;
      $display("[TB] FAIL outputs: got %h/%h required %h/%h",
               adc_left, adc_right, exp_left, exp_right);
    end
  end

  initial begin
    logic [WIDTH-1:0] rw;
    logic [WIDTH-1:0] lw;
    int nl;
    int nr;

    AUD_BCLK    = 1'b0;
    AUD_ADCLRCK = 1'b0;
    AUD_ADCDAT  = 1'b0;
    reset       = 1'b1;
    model_reset();
    #2 reset = 1'b0;

    // Reset held with random pin activity.
    for (int i = 0; i < 60; i++) begin
      #($urandom_range(5, 40));
      AUD_BCLK    = 1'($urandom_range(0, 1));
      AUD_ADCLRCK = 1'($urandom_range(0, 1));
      AUD_ADCDAT  = 1'($urandom_range(0, 1));
    end
    check_output("pulses during reset", 32'(sv_count + err_count), 32'd0);

    // Release in the middle of a right channel.
    AUD_BCLK    = 1'b0;
    AUD_ADCLRCK = 1'b1;
    settle(5);
    @(negedge CLOCK_50) reset = 1'b1;
    settle(2);
    half_ns = 163;
    send_slot(1'b1, WIDTH'($urandom), 28);
    settle(10);
    check_output("no pair from partial frame", 32'(sv_count), 32'd0);

    // Nominal 32-bit slots.
    for (int i = 0; i < 3; i++) send_frame(24'h123456, 24'hABCDEF, 31);
    settle(10);
    check_output("nominal left", 32'(adc_left), 32'h123456);
    check_output("nominal right", 32'(adc_right), 32'hABCDEF);
    check_output("nominal pair count", 32'(sv_count), 32'd3);

    // Exact 24-bit slots.
    for (int i = 0; i < 2; i++) send_frame(24'h800000, 24'h7FFFFF, 24);
    settle(10);
    check_output("exact left", 32'(adc_left), 32'h800000);
    check_output("exact right", 32'(adc_right), 32'h7FFFFF);
    check_output("exact no error", 32'(err_count), 32'd0);

    // Truncated left word: the following right word must be discarded.
    send_slot(1'b0, 24'h0AAAAA, 10);
    send_slot(1'b1, 24'h555555, 31);
    settle(10);
    check_output("truncation error count", 32'(err_count), 32'd1);
    check_output("truncation keeps left", 32'(adc_left), 32'h800000);
    check_output("truncation keeps right", 32'(adc_right), 32'h7FFFFF);
    send_frame(24'h00C0DE, 24'h0BEEF0, 31);
    settle(10);
    check_output("recovery left", 32'(adc_left), 32'h00C0DE);
    check_output("recovery right", 32'(adc_right), 32'h0BEEF0);

    // Reset asserted mid-right-word.
    send_slot(1'b0, 24'h111111, 31);
    send_slot(1'b1, 24'h222222, 12);
    settle(10);
    #4 reset = 1'b0;
    #1;
    check_output("async reset left", 32'(adc_left), 32'h0);
    check_output("async reset right", 32'(adc_right), 32'h0);
    model_reset();
    AUD_BCLK    = 1'b0;
    AUD_ADCLRCK = 1'b1;
    settle(4);
    @(negedge CLOCK_50) reset = 1'b1;
    settle(2);
    send_slot(1'b1, WIDTH'($urandom), 9);
    send_frame(24'h000001, 24'hFFFFFF, 31);
    settle(10);
    check_output("post-reset left", 32'(adc_left), 32'h000001);
    check_output("post-reset right", 32'(adc_right), 32'hFFFFFF);

    // Minimum bit clock, random words and slot lengths with rare truncation.
    half_ns = 60;
    settle(1);
    for (int f = 0; f < 100; f++) begin
      nl = ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, WIDTH - 1))
                                        : int'($urandom_range(WIDTH, 31));
      nr = ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, WIDTH - 1))
                                        : int'($urandom_range(WIDTH, 31));
      lw = WIDTH'($urandom);
      rw = WIDTH'($urandom);
      send_slot(1'b0, lw, nl);
      send_slot(1'b1, rw, nr);
    end
    settle(20);
    check_output("all expected pulses seen", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2s_adc_receiver.md
# i2s_adc_receiver

Deserializes the WM8731 codec's I2S ADC stream (AUD_ADCDAT, framed by AUD_ADCLRCK, clocked by AUD_BCLK) into parallel signed left/right samples in the CLOCK_50 domain. It is the capture-direction counterpart of the DAC serializer in the audio path. It feeds the adc_left/adc_right voice pass-through path of the synth top level. The codec is bus master, so all three audio pins are inputs, asynchronous to CLOCK_50.

## Interface
- WIDTH, 24, sample width in bits per channel (MSB-first, two's complement)
- CLOCK_50  input  1  system clock, 50 MHz; all outputs registered on its rising edge
- reset  input  1  asynchronous, active-low reset (low = in reset)
- AUD_BCLK  input  1  codec bit clock, asynchronous
- AUD_ADCLRCK  input  1  codec ADC frame clock; low = left channel, high = right channel
- AUD_ADCDAT  input  1  codec serial ADC data
- adc_left  output  WIDTH  last complete left sample
- adc_right  output  WIDTH  last complete right sample
- sample_valid  output  1  one-cycle pulse: adc_left/adc_right just updated as a pair
- frame_error  output  1  one-cycle pulse: channel word truncated (LRCK changed before WIDTH bits)

## Operation
- Synchronization: BCLK, ADCLRCK and ADCDAT each pass through two flops. BCLK has a third flop. bclk_rise = sync2 & ~sync3. All three pins share identical delay, so data/LRCK are sampled coherently.
- All protocol state advances only in a CLOCK_50 cycle where bclk_rise = 1. Other cycles hold state.
- At each bclk_rise, the synchronized LRCK is compared with lrck_prev, the LRCK captured at the previous bclk_rise:
  - Changed: this is the I2S one-bit delay slot; the data bit is ignored. If bit_cnt != WIDTH and not in the first slot after reset, pulse frame_error. Set bit_cnt = 0, chan = new LRCK, clear the shift register. Entering left (LRCK low) clears left_ok.
  - Unchanged and bit_cnt < WIDTH: shift = {shift[WIDTH-2:0], data}; bit_cnt++.
  - Unchanged and bit_cnt == WIDTH: bit ignored (slot padding, e.g. 32-bit slots); bit_cnt saturates.
- Word completion happens on the shift that makes bit_cnt reach WIDTH:
  - Left word: left_hold <= completed word; left_ok <= 1.
  - Right word with left_ok = 1: adc_left <= left_hold; adc_right <= completed word; sample_valid pulses; left_ok <= 0.
  - Right word with left_ok = 0: word discarded, outputs unchanged, no pulse. This covers a partial first frame after reset and a left-channel error.
- After reset, the first LRCK edge only establishes alignment. Bits before it are discarded, because bit_cnt resets to WIDTH, which means idle.
- bit_cnt is 5 bits wide (WIDTH ≤ 31).

## Timing
- Reset (reset low, asynchronous): adc_left = 0, adc_right = 0, sample_valid = 0, frame_error = 0, left_hold = 0, shift = 0, bit_cnt = WIDTH, left_ok = 0, synchronizer flops = 0, lrck_prev = 0, first-slot flag set. Deassertion takes effect at the next CLOCK_50 edge.
- Latency: a BCLK rising edge at the pin is first captured by CLOCK_50 edge k. It is acted on at edge k+2; uncertainty is ±1 edge due to metastability.
- adc_left/adc_right change only on the edge that raises sample_valid. Both channels update in the same cycle and then hold for a full frame.
- sample_valid and frame_error are exactly one CLOCK_50 cycle wide and never both high in the same cycle.
- Input constraint: each BCLK high and low phase must span ≥ 3 CLOCK_50 periods. The nominal 3.072 MHz BCLK gives about 8.
- No backpressure: if the consumer misses sample_valid, the next frame overwrites the outputs.

## Test plan
- Reset: hold reset low with random pin activity -> all outputs 0, no pulses. Release, then send one full frame starting mid-right-channel -> no sample_valid until the next complete left+right pair.
- Nominal 32-bit-slot I2S frames, left = 0x123456, right = 0xABCDEF (WIDTH = 24), BCLK = 3.072 MHz -> one sample_valid per frame; adc_left = 0x123456, adc_right = 0xABCDEF, updated together; padding bits 25–31 ignored.
- Exact 24-bit slots (LRCK toggles right after the LSB), left = 0x800000, right = 0x7FFFFF -> outputs 0x800000/0x7FFFFF, no frame_error.
- Truncated left word (LRCK toggles after 10 bits) -> frame_error pulse at the toggle. The following right word is discarded, outputs keep the prior pair, and the next good frame updates normally.
- Reset asserted mid-right-word -> outputs go to 0 immediately (asynchronous). After release, the first full frame 0x000001/0xFFFFFF is reported correctly.
- Minimum BCLK (3 CLOCK_50 cycles per phase), 100 random frames -> every pair matches the scoreboard, no spurious pulses.
